gate_truth_table_tester: RTL
============================

// Module: gate_truth_table_tester
//
// PURPOSE
//   Clocked exhaustive tester that sits on both sides of a small combinational gate under test (e.g. the two-input
//   NAND-built AND). It drives the gate inputs through all 2**N_IN vectors, waits for settling, then samples the gate
//   output. It compares each sample against a parameterised expected truth table and reports pass/fail,
//   an error count and a per-vector failure map. It is the lab-bench stage that feeds and checks every gate exercise.
//
// PARAMETERS
//   N_IN        2        number of gate inputs; vectors run 0 .. 2**N_IN-1
//   SETTLE_CYC  4        cycles each vector is held before sampling; legal range >= 1
//   EXP_TT      4'b1000  expected output; bit k = expected Z for input vector k (default = AND)
//
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              synchronous, active-low reset
//   start      in   1              begin a run; sampled on rising edge
//   dut_in     out  N_IN           registered drive to gate inputs; MSB = first operand (A)
//   dut_out    in   1              gate output Z
//   busy       out  1              high while a run is in progress (SETTLE/SAMPLE)
//   done       out  1              high in DONE until next start or reset
//   pass       out  1              1 = all vectors matched; valid only while done=1
//   err_count  out  N_IN+1         number of mismatching vectors in the last run
//   fail_vec   out  2**N_IN        bit k set = vector k mismatched
//
// BEHAVIOUR
//   - Reset: on any edge with rst_n=0, state=IDLE and every output is 0. This holds mid-run and overrides start.
//   - States: IDLE, SETTLE, SAMPLE, DONE. Internal regs: vec (N_IN bits) and cnt (sized for SETTLE_CYC-1).
//   - IDLE/DONE + start=1: go to SETTLE. Set vec=0, dut_in=0, cnt=0, err_count=0, fail_vec=0, done=0, pass=0.
//     busy rises on the same edge.
//   - IDLE/DONE + start=0: hold. dut_in stays 0 and the result outputs keep their values.
//   - SETTLE: cnt increments every edge. On the edge where cnt==SETTLE_CYC-1, go to SAMPLE.
//   - SAMPLE (one cycle): dut_out is compared with EXP_TT[vec].
//       mismatch -> err_count+1, fail_vec[vec]=1
//       vec < 2**N_IN-1 -> vec+1, dut_in=vec+1, cnt=0, go to SETTLE
//       vec == 2**N_IN-1 -> go to DONE; set done=1, busy=0, dut_in=0
//         pass=1 iff no mismatch in the run, including this final sample
//   - start while busy=1 is ignored; there is no restart mid-run.
//   - Timing: each vector takes SETTLE_CYC+1 cycles. done rises 2**N_IN*(SETTLE_CYC+1) edges after the start edge.
//     That is 20 edges at the defaults.
//   - dut_out is sampled directly. Gate propagation delay must be well under SETTLE_CYC clock periods.
//   - err_count cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
//
// TESTING
//   1. Correct AND gate, defaults, start pulse ->
//      dut_in steps 00,01,10,11, each held 5 cycles; done=1 after 20 edges; pass=1, err_count=0, fail_vec=4'b0000.
//   2. Gate tied to Z=0 ->
//      done after 20 edges; pass=0, err_count=1, fail_vec=4'b1000.
//   3. NAND in place of AND ->
//      pass=0, err_count=4, fail_vec=4'b1111.
//   4. Pulse start again at edge 7 (busy=1) ->
//      ignored; done still at edge 20. Then start in DONE -> outputs clear, new full run.
//   5. rst_n=0 for one cycle at vector 2 ->
//      next edge: busy=0, dut_in=0, err_count=0, fail_vec=0. A later start runs all 4 vectors from 0.
//   6. SETTLE_CYC=1 with correct AND ->
//      each vector held 2 cycles; done after 8 edges; pass=1.

Source files
------------

// File: rtl/gate_truth_table_tester.sv
// ---------------------------------------------------------------------------
// gate_truth_table_tester
//
// Clocked exhaustive tester for a small combinational gate. It walks the gate
// inputs through every vector 0 .. 2**N_IN-1 and holds each one for
// SETTLE_CYC cycles. It then samples the gate output for one cycle and
// compares it with bit 'vec' of EXP_TT.
//
// Results are kept until the next start or reset:
//   - pass      : no vector mismatched (only meaningful while done is high)
//   - err_count : number of mismatching vectors
//   - fail_vec  : one bit per mismatching vector
//
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module gate_truth_table_tester #(
  parameter int unsigned           N_IN       = 2,
  parameter int unsigned           SETTLE_CYC = 4,
  parameter logic [(1<<N_IN)-1:0]  EXP_TT     = 4'b1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [N_IN-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN:0]           err_count,
  output logic [(1<<N_IN)-1:0]    fail_vec
);

  // Number of input vectors in one run.
  localparam int unsigned NVEC  = (1 << N_IN);

  // The settle counter must reach SETTLE_CYC-1. Keep at least one bit so the
  // SETTLE_CYC == 1 case still has a legal vector width.
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = N_IN'(NVEC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                 state_q,     state_d;
  logic [N_IN-1:0]        vec_q,       vec_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [N_IN-1:0]        dut_in_q,    dut_in_d;
  logic                   busy_q,      busy_d;
  logic                   done_q,      done_d;
  logic                   pass_q,      pass_d;
  logic [N_IN:0]          err_count_q, err_count_d;
  logic [NVEC-1:0]        fail_vec_q,  fail_vec_d;
  logic                   mismatch_s;

  // Sampled gate output disagrees with the expected truth-table entry for
  // the current vector. Only acted on in SAMPLE.
  always_comb begin
    mismatch_s = (dut_out != EXP_TT[vec_q]);
  end

  // Next-state and next-output logic.
  always_comb begin
    // Defaults: hold every register.
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    dut_in_d    = dut_in_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Begin a fresh run. All results from the previous run are cleared.
          state_d     = S_SETTLE;
          vec_d       = {N_IN{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          dut_in_d    = {N_IN{1'b0}};
          err_count_d = {(N_IN+1){1'b0}};
          fail_vec_d  = {NVEC{1'b0}};
          done_d      = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
        end else begin
          // Park the gate inputs at zero and keep the last results visible.
          dut_in_d = {N_IN{1'b0}};
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_SAMPLE;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_SAMPLE: begin
        if (mismatch_s) begin
          err_count_d        = err_count_q + {{N_IN{1'b0}}, 1'b1};
          fail_vec_d[vec_q]  = 1'b1;
        end else begin
          err_count_d        = err_count_q;
        end

        if (vec_q == VEC_LAST) begin
          // Last vector: the verdict includes this final sample.
          state_d  = S_DONE;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          dut_in_d = {N_IN{1'b0}};
          pass_d   = (err_count_q == {(N_IN+1){1'b0}}) && !mismatch_s;
        end else begin
          state_d  = S_SETTLE;
          vec_d    = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          dut_in_d = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
          cnt_d    = {CNT_W{1'b0}};
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        state_d     = S_IDLE;
        vec_d       = {N_IN{1'b0}};
        cnt_d       = {CNT_W{1'b0}};
        dut_in_d    = {N_IN{1'b0}};
        busy_d      = 1'b0;
        done_d      = 1'b0;
        pass_d      = 1'b0;
        err_count_d = {(N_IN+1){1'b0}};
        fail_vec_d  = {NVEC{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= {N_IN{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      dut_in_q    <= {N_IN{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= {(N_IN+1){1'b0}};
      fail_vec_q  <= {NVEC{1'b0}};
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      dut_in_q    <= dut_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
